// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM pipeline stage: funct3 size codes,
// control-bit positions inside CRT_MEM/CRT_WB, and the access FSM states.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MEM_READ_BIT  = 0;
  localparam int MEM_WRITE_BIT = 1;
  localparam int BRANCH_BIT    = 2;
  localparam int REGWRITE_BIT  = 0;
  localparam int MEMTOREG_BIT  = 1;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus. The stage is the master; the memory answers with
// dmem_ack, and for loads dmem_rdata is valid in the same cycle as the ack.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_align_unit.sv
// Byte-lane logic: store enable/replication, misalign/illegal detection for a
// new request, and extraction/extension of the returned load word.
module mem_align_unit
  import mem_stage_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr_lo,
  input  logic        req_is_store,
  input  logic [31:0] store_data,
  output logic [3:0]  store_be,
  output logic [31:0] store_wdata,
  output logic        access_err,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic        illegal;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    store_be    = 4'b0000;
    store_wdata = store_data;
    illegal     = 1'b1;
    misaligned  = 1'b0;
    case (req_funct3)
      F3_B: begin
        store_be    = 4'b0001 << req_addr_lo;
        store_wdata = {4{store_data[7:0]}};
        illegal     = 1'b0;
      end
      F3_H: begin
        store_be    = 4'b0011 << {req_addr_lo[1], 1'b0};
        store_wdata = {2{store_data[15:0]}};
        illegal     = 1'b0;
        misaligned  = req_addr_lo[0];
      end
      F3_W: begin
        store_be    = 4'b1111;
        illegal     = 1'b0;
        misaligned  = |req_addr_lo;
      end
      // Unsigned sizes exist only for loads
      F3_BU: illegal = req_is_store;
      F3_HU: begin
        illegal    = req_is_store;
        misaligned = req_addr_lo[0];
      end
      default: illegal = 1'b1;
    endcase
    access_err = illegal | misaligned;
  end

  assign ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
  assign ld_half = ld_word[{ld_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = 32'h0;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data = ld_word;
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one data-memory access at a time over the req/ack
// bus, back-pressures EXE while it waits, and loads the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        in_ready,
  input  logic [2:0]  crt_mem_in,
  input  logic [1:0]  crt_wb_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] dato_b_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic        zero_in,
  input  logic [31:0] pc_branch_in,
  output logic        pc_src_out,
  output logic [31:0] pc_branch_out,
  mem_stage_if.master dmem,
  output logic        wb_valid,
  output logic [1:0]  crt_wb_out,
  output logic [31:0] mem_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        mem_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        cap_is_load_reg;
  logic [1:0]  cap_crt_wb_reg;
  logic [4:0]  cap_rd_reg;
  logic [2:0]  cap_funct3_reg;
  logic [1:0]  cap_addr_lo_reg;
  logic [31:0] cap_alu_reg;

  logic        accept, is_store, is_load, mem_op;
  logic        issue, direct_wb, direct_err, finish_ok, finish_to;
  logic [3:0]  store_be;
  logic [31:0] store_wdata, ld_data;
  logic        access_err;

  assign in_ready      = (state_reg == IDLE);
  assign accept        = valid_in & in_ready;
  assign is_store      = crt_mem_in[MEM_WRITE_BIT];
  assign is_load       = crt_mem_in[MEM_READ_BIT] & ~is_store;
  assign mem_op        = is_store | is_load;
  assign pc_src_out    = accept & crt_mem_in[BRANCH_BIT] & zero_in;
  assign pc_branch_out = pc_branch_in;

  mem_align_unit u_align (
    .req_funct3  (funct3_in),
    .req_addr_lo (alu_result_in[1:0]),
    .req_is_store(is_store),
    .store_data  (dato_b_in),
    .store_be    (store_be),
    .store_wdata (store_wdata),
    .access_err  (access_err),
    .ld_funct3   (cap_funct3_reg),
    .ld_addr_lo  (cap_addr_lo_reg),
    .ld_word     (dmem.dmem_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    issue      = 1'b0;
    direct_wb  = 1'b0;
    direct_err = 1'b0;
    finish_ok  = 1'b0;
    finish_to  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (mem_op && !access_err) begin
            issue      = 1'b1;
            cnt_next   = 8'd0;
            state_next = WAIT_ACK;
          end else begin
            direct_wb  = 1'b1;
            direct_err = mem_op;
          end
        end
      end
      WAIT_ACK: begin
        // An ack in the final counted cycle still completes normally
        if (dmem.dmem_ack) begin
          finish_ok  = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          finish_to  = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= 8'd0;
      cap_is_load_reg <= 1'b0;
      cap_crt_wb_reg  <= 2'b00;
      cap_rd_reg      <= 5'd0;
      cap_funct3_reg  <= 3'b000;
      cap_addr_lo_reg <= 2'b00;
      cap_alu_reg     <= 32'h0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'h0;
      dmem.dmem_wdata <= 32'h0;
      dmem.dmem_be    <= 4'b0000;
      wb_valid        <= 1'b0;
      mem_err         <= 1'b0;
      crt_wb_out      <= 2'b00;
      mem_data_out    <= 32'h0;
      alu_result_out  <= 32'h0;
      rd_out          <= 5'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wb_valid  <= direct_wb | finish_ok | finish_to;
      mem_err   <= direct_err | finish_to;

      if (issue) begin
        cap_is_load_reg <= is_load;
        cap_crt_wb_reg  <= crt_wb_in;
        cap_rd_reg      <= rd_in;
        cap_funct3_reg  <= funct3_in;
        cap_addr_lo_reg <= alu_result_in[1:0];
        cap_alu_reg     <= alu_result_in;
        dmem.dmem_req   <= 1'b1;
        dmem.dmem_we    <= is_store;
        dmem.dmem_addr  <= {alu_result_in[31:2], 2'b00};
        dmem.dmem_wdata <= store_wdata;
        dmem.dmem_be    <= store_be;
      end else if (finish_ok || finish_to) begin
        dmem.dmem_req <= 1'b0;
      end

      if (direct_wb) begin
        crt_wb_out     <= {crt_wb_in[MEMTOREG_BIT], crt_wb_in[REGWRITE_BIT] & ~direct_err};
        mem_data_out   <= 32'h0;
        alu_result_out <= alu_result_in;
        rd_out         <= rd_in;
      end else if (finish_ok || finish_to) begin
        crt_wb_out     <= {cap_crt_wb_reg[MEMTOREG_BIT], cap_crt_wb_reg[REGWRITE_BIT] & ~finish_to};
        mem_data_out   <= (finish_ok && cap_is_load_reg) ? ld_data : 32'h0;
        alu_result_out <= cap_alu_reg;
        rd_out         <= cap_rd_reg;
      end
    end
  end

endmodule
